ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
// - MIPS instruction-fetch stage: owns the PC, drives lookup addresses into the instruction cache, retires responses into a small fetch queue.
// - Re-issues missed addresses and flushes on branch/jump redirect.
// - Sits between the instruction cache (upstream of it for addresses, downstream for instructions) and the decode stage.
// PARAMETERS
// - RESET_PC  32'h0000_0000  first fetch address after reset (bits[1:0] must be 0)
// - DEPTH     4              fetch-queue entries (power of 2, >=2)
// - CNT_W     16             width of the miss counter
// PORTS
// - clk          in   1      single clock, rising edge
// - reset        in   1      asynchronous, active-low (asserted when 0)
// - ic_addr      out  32     lookup address presented to the icache
// - ic_instr     in   32     icache instruction; response for the ic_addr of the previous cycle
// - ic_hit       in   1      icache hit flag; response for the ic_addr of the previous cycle
// - redirect_vld in   1      branch/jump taken; flush and restart fetch
// - redirect_pc  in   32     new fetch PC; bits[1:0] are forced to 0
// - dq_vld       out  1      queue head valid toward decode
// - dq_rdy       in   1      decode accepts head this cycle
// - dq_pc        out  32     PC of head instruction
// - dq_instr     out  32     head instruction word
// - miss_cnt     out  CNT_W  saturating count of icache misses seen
// BEHAVIOUR
// - Reset (reset==0, async): fetch_pc=RESET_PC, ic_addr=RESET_PC, queue empty, dq_vld=0, dq_pc=0, dq_instr=0, miss_cnt=0, rsp_vld_q=0, state=S_BOOT.
// - FSM: S_BOOT -> S_RUN after one clock. S_RUN -> S_FULL when (count+rsp_vld_q)==DEPTH with no pop. S_FULL -> S_RUN when a slot frees. Any state + redirect -> S_RUN.
// - ic_addr = fetch_pc (registered; no combinational path from inputs).
// - Issue in cycle t iff: state==S_RUN, no redirect_vld, no miss being resolved, (count+rsp_vld_q)<DEPTH.
// - Issue: rsp_pc_q<=fetch_pc, rsp_vld_q<=1, fetch_pc<=fetch_pc+4. Non-issue: rsp_vld_q<=0, fetch_pc held.
// - Response in t+1 (rsp_vld_q==1) with ic_hit=1: push {rsp_pc_q, ic_instr}. Sustained rate is 1 instr/cycle.
// - Response with ic_hit=0: nothing pushed. fetch_pc<=rsp_pc_q, so the missed address is re-presented next cycle; no issue this cycle. miss_cnt+=1, saturating at all-ones.
// - Redirect (highest priority): count<=0, rsp_vld_q<=0, fetch_pc<={redirect_pc[31:2],2'b00}. The in-flight response is discarded, any dq_rdy pop is ignored, and there is no issue this cycle. The first new address appears on ic_addr next cycle.
// - Queue: dq_vld=(count!=0); head is dq_pc/dq_instr. Pop when dq_vld&&dq_rdy. Push and pop in the same cycle are legal at any count.
// - Issue credit counts outstanding responses, so a push never finds the queue full (no overflow possible).
// - PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
// - dq_pc/dq_instr are don't-care while dq_vld=0; the bench checks them only when valid.
// - Reset mid-operation: all state is cleared immediately, including in-flight responses and queue contents. Fetch restarts at RESET_PC via S_BOOT.
// STRUCTURE
// - Package mips_fetch_pkg: typedef enum logic[1:0] {S_BOOT,S_RUN,S_FULL} fetch_state_t; WORD_BYTES=4; typedef struct packed {logic[31:0] pc; logic[31:0] instr;} fetch_entry_t.
// - Sub-module fetch_fifo: DEPTH x fetch_entry_t circular buffer. Ports: push, pop, flush, count, head; same async active-low reset.
// - ifetch_unit: PC register, FSM, response tracking, miss counter.
// TESTING
// - T1 boot, all hits, dq_rdy=1, RESET_PC=0 -> ic_addr 0,4,8,... one per cycle; first dq_vld 3 cycles after reset release with dq_pc=0; then consecutive pcs every cycle.
// - T2 ic_hit=0 on the response for 0x8 -> response for 0xC discarded; ic_addr=0x8 next cycle then 0xC; dq order 0x0,0x4,0x8,0xC with no gaps; miss_cnt=1.
// - T3 dq_rdy=0, DEPTH=4 -> exactly 4 entries (0x0-0xC), ic_addr holds 0x10, S_FULL. Set dq_rdy=1 -> fetch resumes at 0x10; no entry is lost or duplicated.
// - T4 redirect_vld with redirect_pc=0x43 while 3 entries queued and 1 in flight -> dq_vld=0 next cycle; ic_addr=0x40; first dq_pc after redirect is 0x40.
// - T5 redirect to 0xFFFF_FFF8 -> dq_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
// - T6 reset pulsed low mid-stream with 2 queued and 1 miss pending -> dq_vld=0, miss_cnt=0, ic_addr=RESET_PC immediately; clean T1 behaviour after release.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS instruction-fetch stage: FSM states and
// the fetch-queue entry layout.
package mips_fetch_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FULL
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries feeding decode.
// Flush empties the queue in one cycle without touching stored words.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t      mem_q [DEPTH];
  logic [PW-1:0]     wrPtr_q;
  logic [PW-1:0]     rdPtr_q;
  logic [CW-1:0]     count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= push_entry;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign count = count_q;
  assign head  = mem_q[rdPtr_q];

endmodule

// File: rtl/ifetch_unit.sv
// MIPS fetch stage: owns the PC, issues icache lookups, retires hits into
// the fetch queue, replays misses and restarts on redirect.
module ifetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      ic_addr,
  input  logic [31:0]      ic_instr,
  input  logic             ic_hit,
  input  logic             redirect_vld,
  input  logic [31:0]      redirect_pc,
  output logic             dq_vld,
  input  logic             dq_rdy,
  output logic [31:0]      dq_pc,
  output logic [31:0]      dq_instr,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  fetch_state_t      state_q, state_d;
  logic [31:0]       fetchPc_q, fetchPc_d;
  logic [31:0]       rspPc_q, rspPc_d;
  logic              rspVld_q, rspVld_d;
  logic [CNT_W-1:0]  missCnt_q, missCnt_d;

  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  fetch_entry_t      head;
  fetch_entry_t      pushEntry;
  logic              rspHit, rspMiss, issue, pop;

  // Credit includes the in-flight response so a hit can always be pushed.
  always_comb begin
    rspHit      = rspVld_q && ic_hit && !redirect_vld;
    rspMiss     = rspVld_q && !ic_hit && !redirect_vld;
    pop         = dq_vld && dq_rdy && !redirect_vld;
    outstanding = count + {{(CW-1){1'b0}}, rspVld_q};
    issue       = (state_q == S_RUN) && !redirect_vld && !rspMiss &&
                  (outstanding < DEPTH_C);
    pushEntry   = '{pc: rspPc_q, instr: ic_instr};
  end

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    rspPc_d   = rspPc_q;
    rspVld_d  = issue;
    missCnt_d = missCnt_q;

    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (outstanding == DEPTH_C && !pop && !rspMiss) state_d = S_FULL;
      end
      S_FULL: begin
        if (pop || rspMiss) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase

    if (issue) begin
      rspPc_d   = fetchPc_q;
      fetchPc_d = fetchPc_q + 32'(WORD_BYTES);
    end

    // A miss rewinds the PC so the same address is looked up again.
    if (rspMiss) begin
      fetchPc_d = rspPc_q;
      if (missCnt_q != '1) missCnt_d = missCnt_q + CNT_W'(1);
    end

    if (redirect_vld) begin
      state_d   = S_RUN;
      fetchPc_d = redirect_pc & ~32'd3;
      rspVld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_BOOT;
      fetchPc_q <= RESET_PC;
      rspPc_q   <= '0;
      rspVld_q  <= 1'b0;
      missCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      rspPc_q   <= rspPc_d;
      rspVld_q  <= rspVld_d;
      missCnt_q <= missCnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rspHit),
    .push_entry (pushEntry),
    .pop        (pop),
    .flush      (redirect_vld),
    .count      (count),
    .head       (head)
  );

  assign ic_addr  = fetchPc_q;
  assign dq_vld   = (count != '0);
  assign dq_pc    = head.pc;
  assign dq_instr = head.instr;
  assign miss_cnt = missCnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: an icache model answers each lookup one
// cycle later and a scoreboard queue holds the PCs decode should receive.
module tb_ifetch_unit;
  import mips_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ic_addr;
  logic [31:0] ic_instr;
  logic        ic_hit;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        dq_vld;
  logic        dq_rdy;
  logic [31:0] dq_pc;
  logic [31:0] dq_instr;
  logic [15:0] miss_cnt;

  int          total = 0;
  int          bad = 0;
  int          popCnt = 0;
  logic [31:0] sbQ[$];
  logic [31:0] prevAddr;
  logic [31:0] missAddr;
  logic        missArm;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ic_addr      (ic_addr),
    .ic_instr     (ic_instr),
    .ic_hit       (ic_hit),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .dq_vld       (dq_vld),
    .dq_rdy       (dq_rdy),
    .dq_pc        (dq_pc),
    .dq_instr     (dq_instr),
    .miss_cnt     (miss_cnt)
  );

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[31:16]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle's dequeue at the falling edge, then advances one
  // clock and answers the previous lookup like the icache would.
  task automatic applyStimulus();
    logic [31:0] expPc;
    @(negedge clk);
    if (reset && dq_vld && dq_rdy && !redirect_vld) begin
      total++;
      assert (sbQ.size() != 0)
      else begin
        bad++;
        $error("[TB] FAIL sbUnexpected observed=%h expected=none", dq_pc);
      end
      if (sbQ.size() != 0) begin
        expPc = sbQ.pop_front();
        checkOutput("sbPc", dq_pc, expPc);
        checkOutput("sbInstr", dq_instr, instrOf(expPc));
      end
      popCnt++;
    end
    prevAddr = ic_addr;
    @(posedge clk);
    #1;
    redirect_vld = 1'b0;
    ic_instr     = instrOf(prevAddr);
    ic_hit       = 1'b1;
    if (missArm && prevAddr === missAddr) begin
      ic_hit  = 1'b0;
      missArm = 1'b0;
    end
  endtask

  task automatic pushRange(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sbQ.push_back(start + 32'(4 * i));
  endtask

  task automatic drainScoreboard(input string tag, input int budget);
    int n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    total++;
    assert (sbQ.size() == 0)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d left expected=0 left", tag, sbQ.size());
    end
  endtask

  task automatic doReset(input logic rdy);
    reset        = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    dq_rdy       = rdy;
    missArm      = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rstIcAddr", ic_addr, 32'h0);
    checkOutput("rstDqVld", {31'b0, dq_vld}, 32'h0);
    checkOutput("rstMissCnt", {16'b0, miss_cnt}, 32'h0);
    checkOutput("rstDqPc", dq_pc, 32'h0);
    checkOutput("rstDqInstr", dq_instr, 32'h0);
    sbQ.delete();
    popCnt = 0;
    reset  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    ic_instr     = 32'h0;
    ic_hit       = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = 32'h0;
    dq_rdy       = 1'b0;
    missAddr     = 32'h0;
    missArm      = 1'b0;
    prevAddr     = 32'h0;

    // T1: boot and stream with all hits
    doReset(1'b1);
    pushRange(32'h0, 16);
    applyStimulus();
    checkOutput("t1Addr1", ic_addr, 32'h0);
    checkOutput("t1Vld1", {31'b0, dq_vld}, 32'h0);
    applyStimulus();
    checkOutput("t1Addr2", ic_addr, 32'h4);
    checkOutput("t1Vld2", {31'b0, dq_vld}, 32'h0);
    applyStimulus();
    checkOutput("t1Addr3", ic_addr, 32'h8);
    checkOutput("t1Vld3", {31'b0, dq_vld}, 32'h1);
    checkOutput("t1FirstPc", dq_pc, 32'h0);
    repeat (16) applyStimulus();
    checkOutput("t1Rate", 32'(popCnt), 32'd16);
    checkOutput("t1Left", 32'(sbQ.size()), 32'd0);
    checkOutput("t1AddrRun", ic_addr, 32'h48);

    // T2: miss on the lookup of 0x8
    doReset(1'b1);
    missAddr = 32'h8;
    missArm  = 1'b1;
    pushRange(32'h0, 6);
    repeat (5) applyStimulus();
    checkOutput("t2Reissue", ic_addr, 32'h8);
    checkOutput("t2MissCnt", {16'b0, miss_cnt}, 32'h1);
    applyStimulus();
    checkOutput("t2NextAddr", ic_addr, 32'hC);
    drainScoreboard("t2Drain", 20);
    checkOutput("t2MissCntEnd", {16'b0, miss_cnt}, 32'h1);

    // T3: decode stalled until the queue fills
    doReset(1'b0);
    pushRange(32'h0, 8);
    repeat (6) applyStimulus();
    checkOutput("t3HoldAddr", ic_addr, 32'h10);
    checkOutput("t3Vld", {31'b0, dq_vld}, 32'h1);
    checkOutput("t3State", {30'b0, dut.state_q}, {30'b0, S_FULL});
    repeat (3) applyStimulus();
    checkOutput("t3StillHold", ic_addr, 32'h10);
    checkOutput("t3NoPop", 32'(popCnt), 32'd0);
    dq_rdy = 1'b1;
    drainScoreboard("t3Drain", 30);

    // T4: redirect with 3 queued and 1 in flight
    doReset(1'b0);
    repeat (5) applyStimulus();
    checkOutput("t4PreVld", {31'b0, dq_vld}, 32'h1);
    redirect_vld = 1'b1;
    redirect_pc  = 32'h43;
    dq_rdy       = 1'b1;
    sbQ.delete();
    pushRange(32'h40, 4);
    applyStimulus();
    checkOutput("t4Vld", {31'b0, dq_vld}, 32'h0);
    checkOutput("t4Addr", ic_addr, 32'h40);
    checkOutput("t4PopIgnored", 32'(popCnt), 32'd0);
    drainScoreboard("t4Drain", 20);

    // T5: redirect near the top of the address space
    redirect_vld = 1'b1;
    redirect_pc  = 32'hFFFF_FFF8;
    sbQ.delete();
    pushRange(32'hFFFF_FFF8, 4);
    applyStimulus();
    checkOutput("t5Addr", ic_addr, 32'hFFFF_FFF8);
    checkOutput("t5Vld", {31'b0, dq_vld}, 32'h0);
    drainScoreboard("t5Drain", 20);

    // T6: reset while 2 are queued and a miss is being resolved
    doReset(1'b0);
    missAddr = 32'h8;
    missArm  = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("t6PreVld", {31'b0, dq_vld}, 32'h1);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6RstVld", {31'b0, dq_vld}, 32'h0);
    checkOutput("t6RstMiss", {16'b0, miss_cnt}, 32'h0);
    checkOutput("t6RstAddr", ic_addr, 32'h0);
    sbQ.delete();
    missArm = 1'b0;
    applyStimulus();
    reset  = 1'b1;
    dq_rdy = 1'b1;
    popCnt = 0;
    pushRange(32'h0, 8);
    applyStimulus();
    applyStimulus();
    checkOutput("t6Vld2", {31'b0, dq_vld}, 32'h0);
    applyStimulus();
    checkOutput("t6Vld3", {31'b0, dq_vld}, 32'h1);
    checkOutput("t6FirstPc", dq_pc, 32'h0);
    drainScoreboard("t6Drain", 20);
    checkOutput("t6MissEnd", {16'b0, miss_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
